// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and one SRAM responder.
// HCLK/HRESET stay outside the bundle as plain module ports.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// Word-addressed AHB-Lite SRAM responder with programmable wait states and a
// two-cycle ERROR response for misaligned or out-of-range accesses.
module ahb_sram_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          ready_state;
    logic          accept;
    logic          addr_err;
    logic          unused_htrans;

    // A new address phase can only be taken in a state that ends a data phase.
    assign ready_state   = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
    assign accept        = ready_state && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign addr_err      = (bus.HADDR[1:0] != 2'b00) ||
                           ({2'b00, bus.HADDR[31:2]} >= 32'(DEPTH));
    assign unused_htrans = bus.HTRANS[0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q  <= bus.HADDR[AW+1:2];
                write_q <= bus.HWRITE;
                err_q   <= addr_err;
            end
        end
    end

    // RAM is not reset; a reset edge drops any pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_LAST && write_q && !err_q)
            mem[addr_q] <= bus.HWDATA;
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;

        case (state)
            S_WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (cnt == 4'd0)
                    state_next = S_LAST;
                else
                    cnt_next = cnt - 4'd1;
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                state_next    = S_ERR2;
            end
            S_IDLE, S_LAST, S_ERR2: begin
                bus.HRESP = (state == S_ERR2);
                if (!accept) begin
                    state_next = S_IDLE;
                end else if (addr_err) begin
                    state_next = S_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_next = S_LAST;
                end else begin
                    state_next = S_WAIT;
                    cnt_next   = 4'(WAIT_STATES - 1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        if ((state == S_WAIT || state == S_LAST) && !write_q && !err_q)
            bus.HRDATA = mem[addr_q];
    end
endmodule
